// File: rtl/controlador_entrada_tempo.sv
// Keypad time-entry sequencer: debounces a one-hot key press, enables the encoder,
// shifts the BCD digit into a 4-digit MM:SS register and waits for release.
// Optional beep output is built only when TECLA_BEEP_EN is defined.
module controlador_entrada_tempo #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  teclado,
    input  logic [3:0]  bcd_in,
    input  logic        habilitar,
    input  logic        limpar,
    output logic        enablen,
    output logic [15:0] tempo,
    output logic [2:0]  num_digitos,
    output logic        cheio,
    output logic        dado_valido
`ifdef TECLA_BEEP_EN
    ,
    output logic        bip
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || BEEP_CYCLES < 1) begin : g_param_check
        $error("controlador_entrada_tempo: DEBOUNCE_CYCLES and BEEP_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ESPERA,
        FILTRO,
        CAPTURA,
        SOLTA
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [9:0]      chave, chave_n;
    logic [15:0]     tempo_n;
    logic [2:0]      num_n;
    logic            valido_n;
    logic            enablen_n;
    logic            tecla_valida;

    // Exactly one key line high: non-zero and clearing the lowest set bit leaves nothing.
    assign tecla_valida = (teclado != '0) && ((teclado & (teclado - 10'd1)) == '0);

    assign cheio = (num_digitos == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ESPERA;
            cnt         <= '0;
            chave       <= '0;
            tempo       <= '0;
            num_digitos <= '0;
            dado_valido <= 1'b0;
            enablen     <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            chave       <= chave_n;
            tempo       <= tempo_n;
            num_digitos <= num_n;
            dado_valido <= valido_n;
            enablen     <= enablen_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        chave_n  = chave;
        tempo_n  = tempo;
        num_n    = num_digitos;
        valido_n = 1'b0;

        // Clearing forces a clean release so a key still held is not re-captured.
        if (limpar) begin
            state_n = SOLTA;
            cnt_n   = '0;
            tempo_n = '0;
            num_n   = '0;
        end else begin
            case (state)
                ESPERA: begin
                    if (habilitar && tecla_valida) begin
                        chave_n = teclado;
                        cnt_n   = '0;
                        state_n = FILTRO;
                    end
                end
                FILTRO: begin
                    if ((teclado != chave) || !habilitar) begin
                        state_n = ESPERA;
                    end else if (cnt == CNT_LAST) begin
                        state_n = CAPTURA;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                CAPTURA: begin
                    if ((num_digitos < 3'd4) && (bcd_in <= 4'd9)) begin
                        tempo_n  = {tempo[11:0], bcd_in};
                        num_n    = num_digitos + 3'd1;
                        valido_n = 1'b1;
                    end
                    cnt_n   = '0;
                    state_n = SOLTA;
                end
                SOLTA: begin
                    if (teclado != '0) begin
                        cnt_n = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = ESPERA;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = ESPERA;
            endcase
        end

        enablen_n = (state_n == ESPERA) || (state_n == SOLTA);
    end

`ifdef TECLA_BEEP_EN
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    logic [BW-1:0] bip_cnt;

    // bip rises together with dado_valido; a new digit restarts the full length.
    always_ff @(posedge clk) begin
        if (reset || limpar) begin
            bip     <= 1'b0;
            bip_cnt <= '0;
        end else if (valido_n) begin
            bip     <= 1'b1;
            bip_cnt <= BW'(BEEP_CYCLES - 1);
        end else if (bip) begin
            if (bip_cnt == '0) begin
                bip <= 1'b0;
            end else begin
                bip_cnt <= bip_cnt - BW'(1);
            end
        end
    end
`endif

endmodule

// File: doc/controlador_entrada_tempo.md
# controlador_entrada_tempo

Sequencing controller for the microwave time-entry keypad path. It watches the raw one-hot keypad lines, debounces a press, enables the `codificador_priori` encoder, and samples its BCD digit. Each accepted digit is shifted into a 4-digit MM:SS time register, and the block then waits for key release before accepting the next press. It sits between the keypad and the timer/display logic inside `entrada_time`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required for a press and for a release. Legal range ≥1.
- `BEEP_CYCLES`, default 8: beep pulse length in cycles. Used only with `TECLA_BEEP_EN`.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `teclado`  in  10  raw keypad lines, bit n = key n. Also routed to the encoder.
- `bcd_in`  in  4  digit returned by the encoder.
- `habilitar`  in  1  entry allowed, i.e. oven not running.
- `limpar`  in  1  clear entered time.
- `enablen`  out  1  encoder enable, active low.
- `tempo`  out  16  {min_dez, min_uni, seg_dez, seg_uni}, BCD.
- `num_digitos`  out  3  digits entered, 0..4.
- `cheio`  out  1  high when `num_digitos == 4`.
- `dado_valido`  out  1  one-cycle pulse per accepted digit.
- `bip`  out  1  beep request. Present only with `TECLA_BEEP_EN`.

## Operation
- A key value is *valid* when exactly one bit of `teclado` is set. Zero bits or more than one bit is never valid.
- Reset values:
  - state = ESPERA
  - `tempo` = 0
  - `num_digitos` = 0
  - `cheio` = 0
  - `dado_valido` = 0
  - `enablen` = 1
  - `bip` = 0
  - debounce counter = 0
  - latched key = 0
- FSM states:
  - **ESPERA**: `enablen` = 1. If `habilitar` is high and `teclado` is valid, latch `teclado`, clear the counter, and go to FILTRO. Otherwise stay.
  - **FILTRO**: `enablen` = 0.
    - If `teclado` ≠ latched key, or `habilitar` is low, go to ESPERA.
    - Else if counter == DEBOUNCE_CYCLES-1, go to CAPTURA.
    - Else increment the counter.
  - **CAPTURA** (one cycle): `enablen` = 0.
    - If `num_digitos` < 4: `tempo` <= {`tempo[11:0]`, `bcd_in`}, `num_digitos` += 1, and `dado_valido` = 1 for the next cycle.
    - If `num_digitos` == 4, the digit is silently dropped with no pulse.
    - Always clear the counter and go to SOLTA.
  - **SOLTA**: `enablen` = 1.
    - If `teclado` ≠ 0, clear the counter.
    - Else if counter == DEBOUNCE_CYCLES-1, go to ESPERA.
    - Else increment the counter.
- `bcd_in` values above 9 are dropped as in the full case: no shift, no pulse.
- `limpar` takes priority over everything except `reset`. It forces `tempo` = 0, `num_digitos` = 0, clears the counter, and sets state = SOLTA. This requires a clean release, so a held key is not captured again.
- `limpar` in the same cycle as CAPTURA: the clear wins and no `dado_valido` is issued.
- `cheio` is derived combinationally from `num_digitos`.
- `habilitar` has no effect on SOLTA or on stored data.
- `reset` asserted mid-debounce or mid-capture returns all outputs to their reset values on that edge.

## Timing
- Count edge 0 as the first rising edge that samples a valid key in ESPERA.
  - FILTRO occupies edges 1..D, where D = DEBOUNCE_CYCLES.
  - CAPTURA is active in the cycle after edge D.
  - `tempo` and `num_digitos` update, and `dado_valido` rises, after edge D+1.
  - `dado_valido` falls after edge D+2.
- `enablen` is low from the cycle after edge 0 through the CAPTURA cycle (D+1 cycles). The encoder output is therefore settled for at least D cycles before it is sampled.
- Release detection: after CAPTURA, ESPERA is re-entered D edges after `teclado` first reads 0 continuously.
- Minimum accepted press-to-press interval: 2D+2 cycles.
- All outputs are registered except `cheio`.

## Configuration
- `TECLA_BEEP_EN`:
  - **Defined**: `bip` port exists. `bip` is driven high for exactly BEEP_CYCLES cycles starting with the `dado_valido` cycle. A new accepted digit restarts the count. `limpar` and `reset` clear `bip` immediately.
  - **Undefined**: no `bip` port and no beep counter. All other behaviour is identical.

## Test plan
- **Single press.** D=4, `habilitar`=1, hold `teclado`=10'b0000100000 (`bcd_in`=5) for 10 cycles.
  - `tempo` becomes 16'h0005 and `num_digitos` = 1 after edge 5.
  - `dado_valido` pulses high for exactly one cycle.
  - `enablen` is low for 5 cycles.
- **Bounce rejection.** Key 7 for 2 cycles, 0 for 1 cycle, key 7 for 2 cycles.
  - No capture; `tempo` unchanged.
  - Then hold 7 stable for ≥6 cycles → one capture only.
- **Four-digit entry with clean releases.** Enter digits 1, 2, 3, 0.
  - `tempo` = 16'h1230 and `cheio` = 1.
  - A fifth press (9) leaves `tempo` = 16'h1230 with no `dado_valido`.
- **Invalid inputs.** `teclado`=10'b0000000110 held 20 cycles → stays in ESPERA, `enablen`=1. Any press with `habilitar`=0 → ignored.
- **Clear behaviour.** Assert `limpar` in the CAPTURA cycle with `tempo`=16'h0012.
  - Result: `tempo`=0, `num_digitos`=0, no pulse.
  - Key still held → no new capture until it is released for ≥D cycles.
- **Reset and beep.** Synchronous `reset` in the middle of FILTRO → all outputs at reset values on the next edge.
  - With `TECLA_BEEP_EN`, an accepted digit gives `bip` high for exactly 8 cycles.
